// File: rtl/invader_edge_ctrl.sv
// invader_edge_ctrl: tracks the invader formation's horizontal extent and
// sequences edge hits, descents and landing once per frame.
// Optional feature: define INVADER_EDGE_DBG_CNT_EN to enable the saturating
// dirChgCnt direction-change counter; otherwise dirChgCnt is tied to zero.
module invader_edge_ctrl #(
  parameter int NUM_COLS     = 8,
  parameter int COL_W        = 32,
  parameter int RIGHT_LIMIT  = 639,
  parameter int LEFT_LIMIT   = 0,
  parameter int BOTTOM_LIMIT = 440,
  parameter int DESC_FRAMES  = 30
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                startOfFrame,
  input  logic                gameActive,
  input  logic [10:0]         topLeftX,
  input  logic [10:0]         topLeftY,
  input  logic [10:0]         formH,
  input  logic [NUM_COLS-1:0] aliveCols,
  output logic                chgDir,
  output logic                descending,
  output logic                landed,
  output logic                dirRight,
  output logic [15:0]         dirChgCnt
);

  localparam int IDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WATCH_R = 3'd1,
    DESC_R  = 3'd2,
    WATCH_L = 3'd3,
    DESC_L  = 3'd4,
    LANDED  = 3'd5
  } state_t;

  state_t             state;
  state_t             nextState;
  logic [7:0]         frameCnt;
  logic [7:0]         nextCnt;
  logic               hitNext;
  logic [IDX_W-1:0]   lo;
  logic [IDX_W-1:0]   hi;
  logic               anyAlive;
  logic signed [11:0] xExt;
  logic signed [11:0] leftEdge;
  logic signed [11:0] rightEdge;
  logic [11:0]        bottomY;
  logic               rightHit;
  logic               leftHit;
  logic               bottomHit;

  // Locate the lowest and highest live columns (scan order gives priority)
  always_comb begin
    lo = {IDX_W{1'b0}};
    hi = {IDX_W{1'b0}};
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      lo = aliveCols[i] ? IDX_W'(i) : lo;
    end
    for (int j = 0; j < NUM_COLS; j++) begin
      hi = aliveCols[j] ? IDX_W'(j) : hi;
    end
  end

  // Formation extents; X is treated as two's complement so a formation
  // partly off the left of the screen yields a small or negative leftEdge
  always_comb begin
    anyAlive  = |aliveCols;
    xExt      = $signed({topLeftX[10], topLeftX});
    leftEdge  = xExt + $signed(12'(32'(lo) * COL_W));
    rightEdge = xExt + $signed(12'((32'(hi) + 32'd1) * COL_W)) - 12'sd1;
    bottomY   = {1'b0, topLeftY} + {1'b0, formH};
    rightHit  = (rightEdge >= $signed(12'(RIGHT_LIMIT)));
    leftHit   = (leftEdge <= $signed(12'(LEFT_LIMIT)));
    bottomHit = (bottomY >= 12'(BOTTOM_LIMIT));
  end

  // Next-state, frame-counter and edge-hit decode
  always_comb begin
    nextState = state;
    nextCnt   = frameCnt;
    hitNext   = 1'b0;
    if (!gameActive) begin
      nextState = IDLE;
      nextCnt   = 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (anyAlive) nextState = WATCH_R;
          else          nextState = IDLE;
        end
        LANDED: nextState = LANDED;
        WATCH_R, DESC_R, WATCH_L, DESC_L: begin
          if (!startOfFrame) begin
            nextState = state;
          end else if (bottomHit) begin
            nextState = LANDED;
            nextCnt   = 8'd0;
          end else if (!anyAlive) begin
            nextState = state;
          end else begin
            case (state)
              WATCH_R: begin
                if (rightHit) begin
                  nextState = DESC_R;
                  nextCnt   = 8'(DESC_FRAMES - 1);
                  hitNext   = 1'b1;
                end else begin
                  nextState = WATCH_R;
                end
              end
              WATCH_L: begin
                if (leftHit) begin
                  nextState = DESC_L;
                  nextCnt   = 8'(DESC_FRAMES - 1);
                  hitNext   = 1'b1;
                end else begin
                  nextState = WATCH_L;
                end
              end
              DESC_R: begin
                if (frameCnt == 8'd0) nextState = WATCH_L;
                else                  nextCnt   = frameCnt - 8'd1;
              end
              DESC_L: begin
                if (frameCnt == 8'd0) nextState = WATCH_R;
                else                  nextCnt   = frameCnt - 8'd1;
              end
              default: nextState = IDLE;
            endcase
          end
        end
        default: begin
          nextState = IDLE;
          nextCnt   = 8'd0;
        end
      endcase
    end
  end

  // FSM state, frame counter and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      frameCnt   <= 8'd0;
      chgDir     <= 1'b0;
      descending <= 1'b0;
      landed     <= 1'b0;
      dirRight   <= 1'b1;
    end else begin
      state      <= nextState;
      frameCnt   <= nextCnt;
      chgDir     <= hitNext;
      descending <= (nextState == DESC_R) || (nextState == DESC_L);
      landed     <= (nextState == LANDED);
      case (nextState)
        WATCH_L, DESC_R: dirRight <= 1'b0;
        LANDED:          dirRight <= dirRight;
        default:         dirRight <= 1'b1;
      endcase
    end
  end

`ifdef INVADER_EDGE_DBG_CNT_EN
  // Saturating count of direction changes, cleared when the game stops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dirChgCnt <= 16'd0;
    end else if (!gameActive) begin
      dirChgCnt <= 16'd0;
    end else if (hitNext && (dirChgCnt != 16'hFFFF)) begin
      dirChgCnt <= dirChgCnt + 16'd1;
    end else begin
      dirChgCnt <= dirChgCnt;
    end
  end
`else
  assign dirChgCnt = 16'd0;
`endif

endmodule

// File: tb/tb_invader_edge_ctrl.sv
// Self-checking bench for invader_edge_ctrl: directed scenarios with literal
// expectations followed by randomized stimulus against a behavioural model.
module tb_invader_edge_ctrl;

  localparam int DESC_FRAMES = 30;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic        gameActive;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic [10:0] formH;
  logic [7:0]  aliveCols;
  logic        chgDir;
  logic        descending;
  logic        landed;
  logic        dirRight;
  logic [15:0] dirChgCnt;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  // Behavioural model: game running?, landed?, moving right?, descent
  // frames still to go, and expected pulse/count.
  bit mActive;
  bit mLanded;
  bit mRight;
  bit mChg;
  int mFramesLeft;
  int mCnt;

  always #5 clk = ~clk;

  invader_edge_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .gameActive   (gameActive),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .formH        (formH),
    .aliveCols    (aliveCols),
    .chgDir       (chgDir),
    .descending   (descending),
    .landed       (landed),
    .dirRight     (dirRight),
    .dirChgCnt    (dirChgCnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int signedX(input logic [10:0] x);
    return x[10] ? (int'(x) - 2048) : int'(x);
  endfunction

  function automatic int lowCol(input logic [7:0] a);
    for (int i = 0; i < 8; i++) if (a[i]) return i;
    return 0;
  endfunction

  function automatic int highCol(input logic [7:0] a);
    for (int i = 7; i >= 0; i--) if (a[i]) return i;
    return 0;
  endfunction

  task automatic modelReset();
    mActive = 1'b0; mLanded = 1'b0; mRight = 1'b1; mChg = 1'b0;
    mFramesLeft = 0; mCnt = 0;
  endtask

  // One clock of game rules, using the inputs the DUT sampled at this edge
  task automatic modelStep();
    int  x;
    bit  hit;
    mChg = 1'b0;
    if (reset || !gameActive) begin
      modelReset();
    end else if (!mActive) begin
      if (aliveCols != 8'h00) mActive = 1'b1;
    end else if (mLanded) begin
      mLanded = 1'b1;
    end else if (startOfFrame) begin
      if (int'(topLeftY) + int'(formH) >= 440) begin
        mLanded = 1'b1;
        mFramesLeft = 0;
      end else if (aliveCols != 8'h00) begin
        if (mFramesLeft > 0) begin
          mFramesLeft--;
        end else begin
          x = signedX(topLeftX);
          if (mRight) hit = (x + (highCol(aliveCols) + 1) * 32 - 1 >= 639);
          else        hit = (x + lowCol(aliveCols) * 32 <= 0);
          if (hit) begin
            mChg = 1'b1;
            mRight = !mRight;
            mFramesLeft = DESC_FRAMES;
`ifdef INVADER_EDGE_DBG_CNT_EN
            if (mCnt < 65535) mCnt++;
`endif
          end
        end
      end
    end
  endtask

  // Compare process: outputs against the model every cycle
  always @(negedge clk) begin
    if (checkEn) begin
      chk("chgDir",     32'(chgDir),     32'(mChg));
      chk("descending", 32'(descending), 32'(mFramesLeft > 0));
      chk("landed",     32'(landed),     32'(mLanded));
      chk("dirRight",   32'(dirRight),   32'(mRight));
      chk("dirChgCnt",  32'(dirChgCnt),  32'(mCnt));
    end
  end

  task automatic tick(input bit sof);
    startOfFrame = sof;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    startOfFrame = 1'b0;
  endtask

  task automatic sofN(input int n);
    for (int k = 0; k < n; k++) tick(1'b1);
  endtask

  task automatic asyncReset();
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    chk("rst_async_desc",  32'(descending), 32'd0);
    chk("rst_async_chg",   32'(chgDir),     32'd0);
    chk("rst_async_dirR",  32'(dirRight),   32'd1);
    chk("rst_async_land",  32'(landed),     32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; gameActive = 1'b0; startOfFrame = 1'b0;
    topLeftX = 11'd0; topLeftY = 11'd100; formH = 11'd40; aliveCols = 8'hFF;
    modelReset();
    checkEn = 1'b1;
    repeat (2) tick(1'b0);
    chk("reset_chg",  32'(chgDir),     32'd0);
    chk("reset_desc", 32'(descending), 32'd0);
    chk("reset_land", 32'(landed),     32'd0);
    chk("reset_dirR", 32'(dirRight),   32'd1);
    chk("reset_cnt",  32'(dirChgCnt),  32'd0);
    reset = 1'b0;

    // Right edge: 638 misses, 639 hits
    gameActive = 1'b1; topLeftX = 11'd383;
    tick(1'b0);
    tick(1'b1);
    chk("r638_chg", 32'(chgDir), 32'd0);
    topLeftX = 11'd384;
    tick(1'b1);
    chk("r639_chg",  32'(chgDir),     32'd1);
    chk("r639_desc", 32'(descending), 32'd1);
    chk("r639_dirR", 32'(dirRight),   32'd0);
    tick(1'b0);
    chk("r_pulse_one", 32'(chgDir), 32'd0);

    // Descent lasts 30 frames (one already consumed 0 so far)
    sofN(DESC_FRAMES - 1);
    chk("desc29_desc", 32'(descending), 32'd1);
    tick(1'b1);
    chk("desc30_desc", 32'(descending), 32'd0);
    chk("desc30_dirR", 32'(dirRight),   32'd0);
    chk("desc30_chg",  32'(chgDir),     32'd0);

    // Partial formation left edge
    aliveCols = 8'h3C; topLeftX = 11'd0;
    tick(1'b1);
    chk("l64_chg", 32'(chgDir), 32'd0);
    topLeftX = 11'd1984;
    tick(1'b1);
    chk("l0_chg",  32'(chgDir),     32'd1);
    chk("l0_desc", 32'(descending), 32'd1);
    chk("l0_dirR", 32'(dirRight),   32'd1);

    // Abort by gameActive=0 with counter at 12
    sofN(17);
    gameActive = 1'b0;
    tick(1'b0);
    chk("ga0_chg",  32'(chgDir),     32'd0);
    chk("ga0_desc", 32'(descending), 32'd0);
    chk("ga0_dirR", 32'(dirRight),   32'd1);
    chk("ga0_land", 32'(landed),     32'd0);

    // Abort by reset in DESC_L with counter at 12
    gameActive = 1'b1; aliveCols = 8'hFF; topLeftX = 11'd384;
    tick(1'b0);
    tick(1'b1);
    sofN(DESC_FRAMES);
    topLeftX = 11'd0;
    tick(1'b1);
    chk("dl_enter_chg", 32'(chgDir), 32'd1);
    sofN(17);
    asyncReset();

    // Landing beats a same-frame right edge hit
    topLeftX = 11'd384;
    tick(1'b0);
    topLeftY = 11'd300; formH = 11'd140;
    tick(1'b1);
    chk("land_land", 32'(landed),     32'd1);
    chk("land_chg",  32'(chgDir),     32'd0);
    chk("land_desc", 32'(descending), 32'd0);
    tick(1'b1);
    chk("land_sticky", 32'(landed), 32'd1);
    gameActive = 1'b0;
    tick(1'b0);
    chk("land_clear", 32'(landed), 32'd0);
    topLeftY = 11'd100; formH = 11'd40;

    // Four edge hits for the debug counter
    gameActive = 1'b1;
    tick(1'b0);
    topLeftX = 11'd384; tick(1'b1); sofN(DESC_FRAMES);
    topLeftX = 11'd0;   tick(1'b1); sofN(DESC_FRAMES);
    topLeftX = 11'd384; tick(1'b1); sofN(DESC_FRAMES);
    topLeftX = 11'd0;   tick(1'b1);
`ifdef INVADER_EDGE_DBG_CNT_EN
    chk("dbg_cnt4", 32'(dirChgCnt), 32'd4);
`else
    chk("dbg_cnt0", 32'(dirChgCnt), 32'd0);
`endif

    // Randomized stimulus against the model
    for (int n = 0; n < 4000; n++) begin
      gameActive = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 9) == 0)
        aliveCols = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      topLeftX = 11'($urandom_range(0, 2047));
      topLeftY = ($urandom_range(0, 199) == 0) ? 11'd420 : 11'($urandom_range(0, 380));
      formH    = 11'd40;
      tick($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 499) == 0) asyncReset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
